// File: rtl/sprite_tile_fetcher.sv
// Sprite tile fetcher: reads the two bitplane bytes of one sprite row from VRAM
// and hands them to the pixel shifter with a one-cycle load strobe.
module sprite_tile_fetcher #(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic              fetch_abort,
    input  logic [7:0]        spr_tile,
    input  logic [7:0]        spr_attr,
    input  logic [3:0]        spr_line,
    input  logic              obj_size16,
    output logic              vram_rd,
    output logic [ADDR_W-1:0] vram_addr,
    input  logic              vram_valid,
    input  logic [7:0]        vram_data,
    input  logic [7:0]        cur_pix_a,
    input  logic [7:0]        cur_pix_b,
    output logic              spr_load,
    output logic [7:0]        spr_pix_a,
    output logic [7:0]        spr_pix_b,
    output logic [7:0]        load_mask,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, RD_LO, RD_HI, LOAD} state_t;

    state_t      state, state_nx;
    logic [7:0]  tile_q;
    logic [7:0]  lo_q;
    logic [3:0]  line_q;
    logic        xflip_q, yflip_q, size16_q;
    logic        accept, lo_take, hi_take, addr_hi;
    logic [3:0]  row;
    logic [11:0] offs;
    logic        unused_attr;

    assign unused_attr = ^{spr_attr[7], spr_attr[4:0]};

    function automatic logic [7:0] mirror(input logic [7:0] b, input logic flip);
        logic [7:0] r;
        r = b;
        if (flip) begin
            for (int unsigned i = 0; i < 8; i++) begin
                r[i] = b[7-i];
            end
        end
        return r;
    endfunction

    always_comb begin
        state_nx = state;
        vram_rd  = 1'b0;
        addr_hi  = 1'b0;
        spr_load = 1'b0;
        accept   = 1'b0;
        lo_take  = 1'b0;
        hi_take  = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_req && !fetch_abort) begin
                    accept   = 1'b1;
                    state_nx = RD_LO;
                end
            end
            RD_LO: begin
                vram_rd = 1'b1;
                if (fetch_abort) begin
                    state_nx = IDLE;
                end else if (vram_valid) begin
                    lo_take  = 1'b1;
                    state_nx = RD_HI;
                end
            end
            RD_HI: begin
                vram_rd = 1'b1;
                addr_hi = 1'b1;
                if (fetch_abort) begin
                    state_nx = IDLE;
                end else if (vram_valid) begin
                    hi_take  = 1'b1;
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                spr_load = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // In 8x16 mode tile bit 0 is replaced by row bit 3 (top/bottom half).
    always_comb begin
        row  = yflip_q ? ~line_q : line_q;
        offs = size16_q ? {tile_q[7:1], row, addr_hi}
                        : {tile_q, row[2:0], addr_hi};
    end

    assign vram_addr = vram_rd ? ADDR_W'(offs) : '0;
    assign load_mask = ~(cur_pix_a | cur_pix_b);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tile_q    <= '0;
            lo_q      <= '0;
            line_q    <= '0;
            xflip_q   <= 1'b0;
            yflip_q   <= 1'b0;
            size16_q  <= 1'b0;
            spr_pix_a <= '0;
            spr_pix_b <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                tile_q   <= spr_tile;
                line_q   <= spr_line;
                xflip_q  <= spr_attr[5];
                yflip_q  <= spr_attr[6];
                size16_q <= obj_size16;
            end
            if (lo_take) begin
                lo_q <= vram_data;
            end
            if (hi_take) begin
                spr_pix_a <= mirror(lo_q, xflip_q);
                spr_pix_b <= mirror(vram_data, xflip_q);
            end
        end
    end

endmodule

// File: tb/tb_sprite_tile_fetcher.sv
// Scoreboard bench for sprite_tile_fetcher: a VRAM responder with programmable
// wait states checks addresses; a load monitor checks pixels, mask and latency.
module tb_sprite_tile_fetcher;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req, fetch_abort;
    logic [7:0]  spr_tile, spr_attr;
    logic [3:0]  spr_line;
    logic        obj_size16;
    logic        vram_rd;
    logic [12:0] vram_addr;
    logic        vram_valid;
    logic [7:0]  vram_data;
    logic [7:0]  cur_pix_a, cur_pix_b;
    logic        spr_load;
    logic [7:0]  spr_pix_a, spr_pix_b, load_mask;
    logic        busy;

    typedef struct {
        logic [7:0] pa;
        logic [7:0] pb;
        logic [7:0] mask;
        int         cyc;
    } exp_t;

    exp_t        sb[$];
    logic [12:0] exp_addr[$];
    logic [7:0]  mem[int];
    int          waits;
    int          cyc;
    int          n_tests;
    int          n_fail;

    sprite_tile_fetcher #(.ADDR_W(13)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_abort(fetch_abort),
        .spr_tile(spr_tile), .spr_attr(spr_attr), .spr_line(spr_line),
        .obj_size16(obj_size16),
        .vram_rd(vram_rd), .vram_addr(vram_addr),
        .vram_valid(vram_valid), .vram_data(vram_data),
        .cur_pix_a(cur_pix_a), .cur_pix_b(cur_pix_b),
        .spr_load(spr_load), .spr_pix_a(spr_pix_a), .spr_pix_b(spr_pix_b),
        .load_mask(load_mask), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // VRAM responder: valid arrives waits+1 cycles after each read request rises
    initial begin
        bit          in_rd;
        int          wcnt;
        logic [12:0] first;
        logic [12:0] ea;
        in_rd      = 1'b0;
        wcnt       = 0;
        first      = '0;
        vram_valid = 1'b0;
        vram_data  = '0;
        forever begin
            @(negedge clk);
            vram_valid = 1'b0;
            if (vram_rd) begin
                if (!in_rd) begin
                    in_rd = 1'b1;
                    wcnt  = 0;
                    first = vram_addr;
                end else begin
                    wcnt++;
                    check("addr_stable", vram_addr, first);
                end
                if (in_rd && wcnt == waits + 1) begin
                    if (exp_addr.size() == 0) begin
                        check("addr_unexpected", vram_rd, 1'b0);
                    end else begin
                        ea = exp_addr.pop_front();
                        check("vram_addr", vram_addr, ea);
                    end
                    vram_data  = mem.exists(int'(vram_addr)) ? mem[int'(vram_addr)] : 8'h00;
                    vram_valid = 1'b1;
                    in_rd      = 1'b0;
                end
            end else begin
                in_rd = 1'b0;
            end
        end
    end

    // Load monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (spr_load) begin
                if (sb.size() == 0) begin
                    check("spurious_load", spr_load, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check("load_cycle", cyc, e.cyc);
                    check("spr_pix_a", spr_pix_a, e.pa);
                    check("spr_pix_b", spr_pix_b, e.pb);
                    check("load_mask", load_mask, e.mask);
                end
            end
        end
    end

    task automatic start_fetch(input logic [7:0] tile, input logic [7:0] attr,
                               input logic [3:0] line, input logic s16,
                               input logic [7:0] lo, input logic [7:0] hi,
                               input logic [12:0] a_lo, input bit expect_load,
                               input logic [7:0] pa, input logic [7:0] pb,
                               input logic [7:0] mask, input int lat);
        exp_t e;
        mem[int'(a_lo)]      = lo;
        mem[int'(a_lo) + 1]  = hi;
        exp_addr.push_back(a_lo);
        exp_addr.push_back(a_lo + 13'd1);
        if (expect_load) begin
            e.pa   = pa;
            e.pb   = pb;
            e.mask = mask;
            e.cyc  = cyc + lat;
            sb.push_back(e);
        end
        spr_tile   = tile;
        spr_attr   = attr;
        spr_line   = line;
        obj_size16 = s16;
        fetch_req  = 1'b1;
        @(negedge clk);
        fetch_req  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check(tag, busy, 1'b0);
    endtask

    task automatic abort_when_hi(input string tag, input bit on_valid);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (vram_rd && vram_addr[0] && (!on_valid || vram_valid)) begin
                hit = 1'b1;
                break;
            end
        end
        check({tag, "_reached"}, hit, 1'b1);
        fetch_abort = 1'b1;
        @(negedge clk);
        fetch_abort = 1'b0;
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_rd"}, vram_rd, 1'b0);
        repeat (3) @(negedge clk);
        check({tag, "_pix_a"}, spr_pix_a, 8'h5A);
        check({tag, "_pix_b"}, spr_pix_b, 8'hC3);
        exp_addr.delete();
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        cyc         = 0;
        waits       = 0;
        rst_n       = 1'b0;
        fetch_req   = 1'b0;
        fetch_abort = 1'b0;
        spr_tile    = '0;
        spr_attr    = '0;
        spr_line    = '0;
        obj_size16  = 1'b0;
        cur_pix_a   = '0;
        cur_pix_b   = '0;
        repeat (3) @(negedge clk);
        check("rst_vram_rd", vram_rd, 1'b0);
        check("rst_vram_addr", vram_addr, 13'h0);
        check("rst_spr_load", spr_load, 1'b0);
        check("rst_pix_a", spr_pix_a, 8'h00);
        check("rst_pix_b", spr_pix_b, 8'h00);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic 8x8 fetch, no flip
        start_fetch(8'h12, 8'h00, 4'd3, 1'b0, 8'hA5, 8'h3C, 13'h126, 1, 8'hA5, 8'h3C, 8'hFF, 5);
        wait_idle("t1_idle");

        // X-flip on palindromes, then back-to-back asymmetric bytes
        start_fetch(8'h12, 8'h20, 4'd3, 1'b0, 8'hA5, 8'h3C, 13'h126, 1, 8'hA5, 8'h3C, 8'hFF, 5);
        wait_idle("t2a_idle");
        start_fetch(8'h12, 8'h20, 4'd3, 1'b0, 8'h01, 8'h80, 13'h126, 1, 8'h80, 8'h01, 8'hFF, 5);
        wait_idle("t2b_idle");

        // 8x16 with and without Y-flip
        start_fetch(8'h13, 8'h40, 4'd9, 1'b1, 8'h11, 8'h22, 13'h12C, 1, 8'h11, 8'h22, 8'hFF, 5);
        wait_idle("t3a_idle");
        start_fetch(8'h13, 8'h00, 4'd9, 1'b1, 8'h33, 8'h44, 13'h132, 1, 8'h33, 8'h44, 8'hFF, 5);
        wait_idle("t3b_idle");

        // Three wait states per byte
        waits = 3;
        start_fetch(8'h12, 8'h00, 4'd3, 1'b0, 8'h5A, 8'hC3, 13'h126, 1, 8'h5A, 8'hC3, 8'hFF, 11);
        wait_idle("t4_idle");

        // Abort while waiting in RD_HI, then abort coincident with valid
        start_fetch(8'h20, 8'h00, 4'd0, 1'b0, 8'hEE, 8'hDD, 13'h200, 0, 8'h00, 8'h00, 8'h00, 0);
        abort_when_hi("t5a", 1'b0);
        waits = 0;
        start_fetch(8'h20, 8'h00, 4'd0, 1'b0, 8'hEE, 8'hDD, 13'h200, 0, 8'h00, 8'h00, 8'h00, 0);
        abort_when_hi("t5b", 1'b1);

        // Load mask, and a request while busy is dropped
        cur_pix_a = 8'hF0;
        cur_pix_b = 8'h0C;
        start_fetch(8'h12, 8'h00, 4'd3, 1'b0, 8'h0F, 8'hF0, 13'h126, 1, 8'h0F, 8'hF0, 8'h03, 5);
        spr_tile  = 8'hFF;
        fetch_req = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        check("t6_busy", busy, 1'b1);
        wait_idle("t6_idle");
        repeat (8) @(negedge clk);
        check("t6_no_queue", busy, 1'b0);
        cur_pix_a = 8'h00;
        cur_pix_b = 8'h00;

        // Reset pulse mid RD_LO
        waits = 3;
        start_fetch(8'h12, 8'h00, 4'd3, 1'b0, 8'h77, 8'h66, 13'h126, 0, 8'h00, 8'h00, 8'h00, 0);
        #1;
        check("t7_in_rdlo", vram_rd, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t7_vram_rd", vram_rd, 1'b0);
        check("t7_vram_addr", vram_addr, 13'h0);
        check("t7_spr_load", spr_load, 1'b0);
        check("t7_pix_a", spr_pix_a, 8'h00);
        check("t7_pix_b", spr_pix_b, 8'h00);
        check("t7_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_addr.delete();
        repeat (4) @(negedge clk);

        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
